conv_encoder_framed: RTL
========================

// Module: conv_encoder_framed
// PURPOSE
// - Rate-1/2, K=7 convolutional encoder (171/133 octal) feeding the channel model and Viterbi decoder.
// - Accepts one data bit per enable, emits one 2-bit symbol per accepted bit.
// - After FRAME_LEN data bits, appends K-1 zero tail bits so the decoder traceback ends in state 0.
// - Supplies the encoder side of the tx/rx chain; symbol format matches the decoder d_in[1:0].
// PARAMETERS
// - FRAME_LEN  256  data bits per frame (>=1)
// - TERMINATE  1    1: append K-1 zero tail symbols per frame; 0: continuous stream, no tail, no framing reset
// PORTS
// - clk            in   1  single clock, all logic on posedge
// - rst            in   1  asynchronous, active-high reset
// - enable_i       in   1  d_in valid this cycle
// - d_in           in   1  data bit
// - ready_o        out  1  encoder accepts d_in this cycle (enable_i & ready_o = accept)
// - valid_o        out  1  d_out holds a new symbol this cycle
// - d_out          out  2  {G0 parity, G1 parity}
// - frame_start_o  out  1  with valid_o: first data symbol of a frame
// - frame_end_o    out  1  with valid_o: last symbol of frame (last tail, or last data if TERMINATE=0)
// - drop_o         out  1  1-cycle pulse: enable_i high while ready_o low, bit discarded
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, shift reg=0, bit count=0; valid_o=0, d_out=2'b00,
//   frame_start_o=0, frame_end_o=0, drop_o=0, ready_o=1.
// - Shift reg s[5:0], s[5] = most recent previous bit. w[6:0] = {bit_in, s[5:0]}.
//   d_out[1] = ^(w & 7'b1111001) (G0=171o); d_out[0] = ^(w & 7'b1011011) (G1=133o).
//   After each symbol: s <= {bit_in, s[5:1]}. bit_in = d_in in DATA, 0 in TAIL.
// - Latency: symbol registered; valid_o/d_out one cycle after acceptance (or after tail cycle).
// - ready_o combinational from state: 1 in IDLE/DATA, 0 in TAIL.
// - FSM:
//   IDLE: accept -> emit symbol with frame_start_o=1, count=1; -> DATA,
//     or -> TAIL if FRAME_LEN==1 (TERMINATE=1).
//   DATA: accept -> emit, count++. On acceptance of bit FRAME_LEN: TERMINATE=1 -> TAIL;
//     TERMINATE=0 -> IDLE with frame_end_o=1 on that symbol, shift reg NOT cleared.
//     No enable -> hold, valid_o=0.
//   TAIL: runs unconditionally 6 consecutive cycles, one zero-input symbol each (valid_o=1).
//     frame_end_o=1 on 6th; -> IDLE, count=0; shift reg is all-zero by construction.
// - Gaps in enable_i within a frame are legal; frame length counts accepted bits only.
// - enable_i during TAIL: bit dropped, drop_o pulses next cycle, state unaffected.
// - Back-to-back frames: first data bit is accepted the cycle after TAIL ends
//   (IDLE lasts >=1 cycle, ready_o=1 in it).
// - rst mid-frame: immediate return to reset state; partial frame discarded, no tail emitted.
// - Counter width $clog2(FRAME_LEN+1); no wrap possible since count clears at frame end.
// STRUCTURE
// - viterbi_pkg: K=7, TAIL_LEN=K-1, G0=7'o171, G1=7'o133, state enum {IDLE,DATA,TAIL}.
// - Sub-module conv_enc_core: shift reg + parity, ports (clk,rst,shift,bit_in,sym_o);
//   shared by the decoder branch-metric generator.
// - Top: FSM, frame counter, handshake/flag registers.
// TESTING
// - Impulse: FRAME_LEN=8, bits 1,0,0,0,0,0,0,0 ->
//   d_out 11,10,11,11,00,01,11,00 then 6 tail 00, frame_end_o on last.
// - All-zero frame (FRAME_LEN=256) -> 262 symbols of 00; frame_start_o once, frame_end_o once;
//   ready_o low exactly 6 cycles.
// - Gapped enable (1 of every 3 cycles), random data -> d_out matches reference model;
//   valid_o only on accept+1.
// - enable_i held high through frame boundary ->
//   6 drop_o pulses during TAIL; next frame starts cycle after IDLE entry.
// - rst asserted after 100 bits -> outputs zero same cycle;
//   next frame's impulse response correct (state cleared).
// - TERMINATE=0, FRAME_LEN=4 -> no tail; frame_end_o every 4th symbol;
//   encoding continuous across frames vs model.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=7, rate-1/2 convolutional encoder and Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned K        = 7;
  localparam int unsigned TAIL_LEN = K - 1;

  // Generator taps: bit K-1 is the newest input bit, bit 0 the oldest.
  localparam logic [K-1:0] G0 = 7'o171;
  localparam logic [K-1:0] G1 = 7'o133;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTail
  } enc_state_e;

  // Symbol for an encoder window w = {bit_in, s[K-2:0]}: {G0 parity, G1 parity}.
  function automatic logic [1:0] conv_sym(input logic [K-1:0] w);
    return {^(w & G0), ^(w & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// K=7 encoder shift register plus parity; sym_o is the symbol for bit_in against the current
// register, and the register advances when shift is high.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       bit_in,
  output logic [1:0] sym_o
);

  logic [K-2:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift) begin
      sr_d = {bit_in, sr_q[K-2:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sym_o = conv_sym({bit_in, sr_q});

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 K=7 encoder: counts FRAME_LEN accepted data bits, then optionally flushes the
// shift register with K-1 zero tail symbols so the decoder traceback ends in state 0.
module conv_encoder_framed
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  parameter bit          TERMINATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       drop_o
);

  localparam int unsigned     CntW     = $clog2(FRAME_LEN + 1);
  localparam int unsigned     TailW    = $clog2(TAIL_LEN);
  localparam logic [CntW-1:0] LastCnt  = CntW'(FRAME_LEN - 1);
  localparam logic [TailW-1:0] TailLast = TailW'(TAIL_LEN - 1);

  enc_state_e       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [TailW-1:0] tail_cnt_q, tail_cnt_d;
  logic             valid_q, valid_d;
  logic [1:0]       d_out_q, d_out_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             drop_q, drop_d;

  logic       in_tail;
  logic       accept;
  logic       shift;
  logic       bit_in;
  logic [1:0] sym;

  assign in_tail = (state_q == StTail);
  assign ready_o = ~in_tail;
  assign accept  = enable_i & ready_o;
  assign shift   = accept | in_tail;
  assign bit_in  = in_tail ? 1'b0 : d_in;

  conv_enc_core u_core (
    .clk    (clk),
    .rst    (rst),
    .shift  (shift),
    .bit_in (bit_in),
    .sym_o  (sym)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    tail_cnt_d    = tail_cnt_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    valid_d       = shift;
    d_out_d       = shift ? sym : d_out_q;
    drop_d        = enable_i & in_tail;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          frame_start_d = 1'b1;
          if (FRAME_LEN == 1) begin
            count_d = '0;
            if (TERMINATE) begin
              state_d = StTail;
            end else begin
              frame_end_d = 1'b1;
            end
          end else begin
            count_d = CntW'(1);
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          if (count_q == LastCnt) begin
            count_d = '0;
            if (TERMINATE) begin
              state_d = StTail;
            end else begin
              // Continuous stream: shift register carries over into the next frame.
              state_d     = StIdle;
              frame_end_d = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StTail: begin
        if (tail_cnt_q == TailLast) begin
          tail_cnt_d  = '0;
          state_d     = StIdle;
          frame_end_d = 1'b1;
        end else begin
          tail_cnt_d = tail_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      count_q       <= '0;
      tail_cnt_q    <= '0;
      valid_q       <= 1'b0;
      d_out_q       <= 2'b00;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tail_cnt_q    <= tail_cnt_d;
      valid_q       <= valid_d;
      d_out_q       <= d_out_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      drop_q        <= drop_d;
    end
  end

  assign valid_o       = valid_q;
  assign d_out         = d_out_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign drop_o        = drop_q;

endmodule
